// File: rtl/prog_ctr_pkg.sv
// rtl/prog_ctr_pkg.sv - shared types and constants for the program counter
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_e;

  // Wide enough for any PCW in use; sliced down at the point of use.
  localparam logic [31:0] PC_RESET = '0;

endpackage

// File: rtl/prog_ctr_branch_lut.sv
// rtl/prog_ctr_branch_lut.sv - branch-target ROM, index to absolute PC
module branch_lut #(
  parameter int PCW = 10,
  parameter int LW  = 5
) (
  input  logic [LW-1:0]  idx,
  output logic [PCW-1:0] target
);

  // Regenerated by the assembler flow per program; unlisted slots jump to 0.
  always_comb begin
    target = '0;
    case (idx)
      LW'(1):  target = PCW'(20);
      LW'(3):  target = PCW'(40);
      LW'(7):  target = {PCW{1'b1}};
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter, run control and retired-instruction counter
module prog_ctr
  import prog_ctr_pkg::*;
#(
  parameter int PCW = 10,
  parameter int LW  = 5,
  parameter int CW  = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic           Branch,
  input  logic           Jump,
  input  logic [LW-1:0]  TargetIdx,
  input  logic           Halt,
  output logic [PCW-1:0] PC,
  output logic           Running,
  output logic           Done,
  output logic [CW-1:0]  InstrCount
);

  pc_state_e      state, state_next;
  logic [PCW-1:0] lut_target;
  logic [CW-1:0]  count_inc;

  branch_lut #(.PCW(PCW), .LW(LW)) u_lut (
    .idx    (TargetIdx),
    .target (lut_target)
  );

  assign count_inc = (InstrCount == {CW{1'b1}}) ? InstrCount : InstrCount + CW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Decoder inputs are only looked at in RUN, so X on them elsewhere is harmless.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (Halt)  state_next = DONE;
      DONE:    if (Start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Running = (state == RUN);
    Done    = (state == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC         <= PC_RESET[PCW-1:0];
      InstrCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          PC         <= PC_RESET[PCW-1:0];
          InstrCount <= '0;
        end
        RUN: begin
          InstrCount <= count_inc;
          if (Halt)                PC <= PC;
          else if (Branch && Jump) PC <= lut_target;
          else                     PC <= PC + PCW'(1);
        end
        DONE: begin
          if (Start) begin
            PC         <= PC_RESET[PCW-1:0];
            InstrCount <= '0;
          end
        end
        default: begin
          PC         <= PC_RESET[PCW-1:0];
          InstrCount <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_ctr.sv
// tb/tb_prog_ctr.sv - directed self-checking bench for prog_ctr
module tb_prog_ctr;

  logic        clk = 1'b0;
  logic        reset, start, branch, jump, halt;
  logic [4:0]  target_idx;
  logic [9:0]  pc;
  logic        running, done;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  prog_ctr #(.PCW(10), .LW(5), .CW(16)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Branch     (branch),
    .Jump       (jump),
    .TargetIdx  (target_idx),
    .Halt       (halt),
    .PC         (pc),
    .Running    (running),
    .Done       (done),
    .InstrCount (instr_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_decoder();
    branch = 1'b0; jump = 1'b0; halt = 1'b0; target_idx = '0;
  endtask

  task automatic restart();
    idle_decoder();
    reset = 1'b1; start = 1'b0;
    step(1);
    reset = 1'b0; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_decoder();
    reset = 1'b1; start = 1'b1;
    step(3);
    vectors++;
    if (pc !== 10'd0 || done !== 1'b0 || running !== 1'b0 || instr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_hold: pc=%0d done=%b running=%b count=%0d, want 0/0/0/0",
               pc, done, running, instr_count);
    end
    reset = 1'b0;
    step(1);
    vectors++;
    if (running !== 1'b1 || pc !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_release: running=%b pc=%0d, want 1/0", running, pc);
    end
    for (int k = 1; k <= 3; k++) begin
      step(1);
      vectors++;
      if (pc !== 10'(k) || instr_count !== 16'(k)) begin
        miscompares++;
        $display("FAIL seq_pc%0d: pc=%0d count=%0d, want %0d/%0d", k, pc, instr_count, k, k);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_branch();
    restart();
    step(5);
    branch = 1'b1; jump = 1'b1; target_idx = 5'd3;
    step(1);
    vectors++;
    if (pc !== 10'd40 || instr_count !== 16'd6) begin
      miscompares++;
      $display("FAIL branch_taken: pc=%0d count=%0d, want 40/6", pc, instr_count);
    end
    restart();
    step(5);
    branch = 1'b1; jump = 1'b0; target_idx = 5'd3;
    step(1);
    vectors++;
    if (pc !== 10'd6) begin
      miscompares++;
      $display("FAIL branch_not_taken: pc=%0d, want 6", pc);
    end
    jump = 1'b1; target_idx = 5'd31;
    step(1);
    vectors++;
    if (pc !== 10'd0 || instr_count !== 16'd7) begin
      miscompares++;
      $display("FAIL branch_unlisted: pc=%0d count=%0d, want 0/7", pc, instr_count);
    end
    idle_decoder();
  endtask

  task automatic test_halt();
    restart();
    step(12);
    halt = 1'b1; branch = 1'b1; jump = 1'b1; target_idx = 5'd3;
    step(1);
    vectors++;
    if (done !== 1'b1 || running !== 1'b0 || pc !== 10'd12 || instr_count !== 16'd13) begin
      miscompares++;
      $display("FAIL halt_priority: done=%b running=%b pc=%0d count=%0d, want 1/0/12/13",
               done, running, pc, instr_count);
    end
    halt = 1'bx; branch = 1'bx; jump = 1'bx; target_idx = 5'bx; start = 1'b0;
    step(2);
    vectors++;
    if (done !== 1'b1 || pc !== 10'd12 || instr_count !== 16'd13) begin
      miscompares++;
      $display("FAIL done_hold_x: done=%b pc=%0d count=%0d, want 1/12/13", done, pc, instr_count);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    idle_decoder();
    vectors++;
    if (running !== 1'b1 || done !== 1'b0 || pc !== 10'd0 || instr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL done_restart: running=%b done=%b pc=%0d count=%0d, want 1/0/0/0",
               running, done, pc, instr_count);
    end
  endtask

  task automatic test_wrap();
    restart();
    branch = 1'b1; jump = 1'b1; target_idx = 5'd7;
    step(1);
    vectors++;
    if (pc !== 10'd1023) begin
      miscompares++;
      $display("FAIL wrap_target: pc=%0d, want 1023", pc);
    end
    idle_decoder();
    step(1);
    vectors++;
    if (pc !== 10'd0 || instr_count !== 16'd2 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pc: pc=%0d count=%0d running=%b, want 0/2/1", pc, instr_count, running);
    end
  endtask

  task automatic test_mid_reset();
    restart();
    branch = 1'b1; jump = 1'b1; target_idx = 5'd1;
    step(1);
    vectors++;
    if (pc !== 10'd20) begin
      miscompares++;
      $display("FAIL pre_reset_pc: pc=%0d, want 20", pc);
    end
    reset = 1'b1; start = 1'b1;
    step(1);
    vectors++;
    if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || instr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: pc=%0d running=%b done=%b count=%0d, want 0/0/0/0",
               pc, running, done, instr_count);
    end
    reset = 1'b0; start = 1'b0;
    idle_decoder();
  endtask

  task automatic test_saturate();
    restart();
    step(65533);
    vectors++;
    if (instr_count !== 16'd65533) begin
      miscompares++;
      $display("FAIL count_pre_sat: count=%0d, want 65533", instr_count);
    end
    step(2);
    vectors++;
    if (instr_count !== 16'hFFFF || pc !== 10'd1023) begin
      miscompares++;
      $display("FAIL count_at_max: count=%0d pc=%0d, want 65535/1023", instr_count, pc);
    end
    step(3);
    vectors++;
    if (instr_count !== 16'hFFFF || pc !== 10'd2) begin
      miscompares++;
      $display("FAIL count_saturate: count=%0d pc=%0d, want 65535/2", instr_count, pc);
    end
    halt = 1'b1;
    step(1);
    vectors++;
    if (instr_count !== 16'hFFFF || done !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_at_max: count=%0d done=%b, want 65535/1", instr_count, done);
    end
    idle_decoder();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    idle_decoder();
    test_reset();
    test_branch();
    test_halt();
    test_wrap();
    test_mid_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
